// File: rtl/press_pulse_conditioner.sv
// press_pulse_conditioner: synchronizes and debounces a raw button into a one-cycle press pulse
module press_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       P1,
  output logic       level,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, ARMING, HIGH, DISARMING} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   p1_q, level_q;
  logic [7:0]             count_q;
  logic                   sync, cnt_last, fire;
  assign sync     = sync_q[SYNC_STAGES-1];
  assign cnt_last = cnt_q == CNT_LAST;
  assign fire     = state_q == ARMING && sync && cnt_last;
  // Any sample opposite to the pending level aborts the transition and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!sync) begin
          state_d = DISARMING;
          cnt_d   = '0;
        end
      end
      DISARMING: begin
        if (sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      p1_q    <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= fire;
      level_q <= state_d == HIGH || state_d == DISARMING;
      count_q <= count_q + {7'd0, fire};
    end
  end
  assign P1          = p1_q;
  assign level       = level_q;
  assign press_count = count_q;
endmodule

// File: tb/tb_press_pulse_conditioner.sv
// tb_press_pulse_conditioner: directed table, corner sequences and random run-length stimulus against a debounce model
module tb_press_pulse_conditioner;
  localparam int S = 2;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       P1, level;
  logic [7:0] press_count;
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int edge_n = 0;
  logic mq[$];
  int   run = 0;
  logic mlev = 1'b0;
  logic mp1 = 1'b0;
  int   mcnt = 0;
  typedef struct {logic r; logic b; logic p1; logic lv; int cnt;} vec_t;
  vec_t tbl[11];
  press_pulse_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .P1(P1), .level(level), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask
  // Model: sync is btn delayed S edges; level flips after D+1 consecutive opposite samples.
  task automatic model(input logic r, input logic b);
    logic s;
    if (r) begin
      mq = {};
      for (int i = 0; i < S; i++) mq.push_back(1'b0);
      run = 0; mlev = 1'b0; mp1 = 1'b0; mcnt = 0;
    end else begin
      s = mq.pop_front();
      mq.push_back(b);
      mp1 = 1'b0;
      run = (s != mlev) ? run + 1 : 0;
      if (run == D + 1) begin
        mlev = s;
        run = 0;
        if (s) begin
          mp1 = 1'b1;
          mcnt = (mcnt + 1) % 256;
        end
      end
    end
  endtask
  task automatic tick(input logic r, input logic b);
    rst = r;
    btn_raw = b;
    @(posedge clk);
    edge_n++;
    model(r, b);
    #1;
    pulses += int'(P1);
    chk("p1", int'(P1), int'(mp1));
    chk("level", int'(level), int'(mlev));
    chk("press_count", int'(press_count), mcnt);
  endtask
  initial begin
    int p0, pe, lmin, len, n;
    logic b;
    for (int i = 0; i < S; i++) mq.push_back(1'b0);
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 3; i < 9; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].b);
      chk("tbl_p1", int'(P1), int'(tbl[i].p1));
      chk("tbl_level", int'(level), int'(tbl[i].lv));
      chk("tbl_count", int'(press_count), tbl[i].cnt);
    end
    p0 = pulses;
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1);
    chk("hold_no_p1", pulses - p0, 0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    chk("release_level_6", int'(level), 1);
    tick(1'b0, 1'b0);
    chk("release_level_7", int'(level), 0);
    chk("release_no_p1", pulses - p0, 0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    chk("repress_count", int'(press_count), 2);
    p0 = pulses;
    lmin = 1;
    for (int i = 0; i < 13; i++) begin
      tick(1'b0, i >= 3);
      if (level == 1'b0) lmin = 0;
    end
    chk("glitch_level", lmin, 1);
    chk("glitch_no_p1", pulses - p0, 0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    p0 = pulses;
    pe = 0;
    for (int i = 1; i <= 26; i++) begin
      tick(1'b0, (i == 2 || i == 5) ? 1'b0 : 1'b1);
      if (P1 && pe == 0) pe = i;
    end
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_edge", pe, 12);
    chk("bounce_count", int'(press_count), 1);
    tick(1'b1, 1'b0);
    p0 = pulses;
    for (int k = 1; k <= 256; k++) begin
      n = pulses;
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
      chk("wrap_press_pulse", pulses - n, 1);
      if (k == 255) chk("wrap_255", int'(press_count), 255);
    end
    chk("wrap_zero", int'(press_count), 0);
    chk("wrap_total", pulses - p0, 256);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst_held_level", int'(level), 0);
    chk("rst_held_p1", int'(P1), 0);
    pe = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b1);
      if (P1 && pe == 0) pe = i;
    end
    chk("rst_held_edge", pe, 7);
    chk("rst_held_count", int'(press_count), 1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst_wins_p1", int'(P1), 0);
    chk("rst_wins_count", int'(press_count), 0);
    n = 0;
    while (n < 3000) begin
      b = 1'(int'($urandom_range(0, 1)));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        tick($urandom_range(0, 199) == 0, b);
        n++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
